// File: rtl/fu_pkg.sv
// Shared opcodes, flag positions and unit decode for functional_unit_core.
// The MADD opcodes only have an effect when the design is built with FU_MADD_EN.
package fu_pkg;

    localparam logic [5:0] OP_INC      = 6'b000000;
    localparam logic [5:0] OP_DEC      = 6'b000001;
    localparam logic [5:0] OP_ADD      = 6'b000010;
    localparam logic [5:0] OP_SUB      = 6'b000011;
    localparam logic [5:0] OP_NEGA     = 6'b000101;
    localparam logic [5:0] OP_AND      = 6'b001000;
    localparam logic [5:0] OP_OR       = 6'b001001;
    localparam logic [5:0] OP_XOR      = 6'b001010;
    localparam logic [5:0] OP_NOTA     = 6'b001101;
    localparam logic [5:0] OP_LT       = 6'b001110;
    localparam logic [5:0] OP_LE       = 6'b001111;
    localparam logic [5:0] OP_EQ0      = 6'b010000;
    localparam logic [5:0] OP_NE0      = 6'b010001;
    localparam logic [5:0] OP_GT0      = 6'b010010;
    localparam logic [5:0] OP_GE0      = 6'b010011;
    localparam logic [5:0] OP_LE0      = 6'b010100;
    localparam logic [5:0] OP_LT0      = 6'b010101;
    localparam logic [5:0] OP_GT       = 6'b010110;
    localparam logic [5:0] OP_GE       = 6'b010111;
    localparam logic [5:0] OP_EQ1      = 6'b011000;
    localparam logic [5:0] OP_NE1      = 6'b011001;
    localparam logic [5:0] OP_GT1      = 6'b011010;
    localparam logic [5:0] OP_GE1      = 6'b011011;
    localparam logic [5:0] OP_LE1      = 6'b011100;
    localparam logic [5:0] OP_LT1      = 6'b011101;
    localparam logic [5:0] OP_EQ       = 6'b011110;
    localparam logic [5:0] OP_NE       = 6'b011111;
    localparam logic [5:0] OP_SHR      = 6'b100000;
    localparam logic [5:0] OP_ASHR1    = 6'b100001;
    localparam logic [5:0] OP_ASHR2    = 6'b100010;
    localparam logic [5:0] OP_SHL      = 6'b100011;
    localparam logic [5:0] OP_ASHR4    = 6'b100100;
    localparam logic [5:0] OP_ASHR     = 6'b100101;
    localparam logic [5:0] OP_ASHR16   = 6'b101000;
    localparam logic [5:0] OP_SEL      = 6'b110000;
    localparam logic [5:0] OP_SEL_A0   = 6'b110001;
    localparam logic [5:0] OP_SEL_A1   = 6'b110010;
    localparam logic [5:0] OP_SEL_01   = 6'b110011;
    localparam logic [5:0] OP_SEL_1OR0 = 6'b110100;

    // MUL/MADD match on INST[5:2]; the low two opcode bits are don't-care
    localparam logic [3:0] OP_MUL_PFX  = 4'b1110;
    localparam logic [3:0] OP_MADD_PFX = 4'b1111;

    localparam int FLAG_N  = 3;
    localparam int FLAG_ZR = 2;
    localparam int FLAG_CY = 1;
    localparam int FLAG_OV = 0;

    localparam int UNIT_ALU_BIT = 5;
    localparam int UNIT_SHF_LSB = 4;
    localparam int UNIT_MM_LSB  = 3;

    typedef enum logic [1:0] {
        UNIT_ALU,
        UNIT_SHIFT,
        UNIT_MADD,
        UNIT_MUX
    } unit_t;

    function automatic unit_t decode_unit(input logic [5:0] op);
        if (!op[UNIT_ALU_BIT])
            return UNIT_ALU;
        else if (!op[UNIT_SHF_LSB])
            return UNIT_SHIFT;
        else if (op[UNIT_MM_LSB])
            return UNIT_MADD;
        else
            return UNIT_MUX;
    endfunction

endpackage

// File: rtl/fu_alu.sv
// Combinational ALU: shared adder for ADD/SUB/NEGA/INC/DEC, bitwise ops and
// signed compares. valid is low for opcodes this unit does not define.
module fu_alu
    import fu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [5:0]  op,
    output logic [31:0] result,
    output logic        cy,
    output logic        ov,
    output logic        valid
);

    logic [31:0] add_x;
    logic [31:0] add_y;
    logic        add_cin;
    logic [32:0] sum;
    logic        add_ovf;
    logic        lt_ab;
    logic        eq_ab;
    logic        a_neg;
    logic        a_zero;
    logic        a_one;

    // Subtraction-style ops reuse the single adder as x + ~y + 1
    always_comb begin
        add_x   = a;
        add_y   = b;
        add_cin = 1'b0;
        case (op)
            OP_SUB:  begin add_y = ~b; add_cin = 1'b1; end
            OP_NEGA: begin add_x = 32'd0; add_y = ~a; add_cin = 1'b1; end
            OP_INC:  add_y = 32'd1;
            OP_DEC:  add_y = 32'hFFFF_FFFF;
            default: ;
        endcase
    end

    assign sum     = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};
    assign add_ovf = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);

    assign lt_ab  = $signed(a) < $signed(b);
    assign eq_ab  = (a == b);
    assign a_neg  = a[31];
    assign a_zero = (a == 32'd0);
    assign a_one  = (a == 32'd1);

    always_comb begin
        result = 32'd0;
        cy     = 1'b0;
        ov     = 1'b0;
        valid  = 1'b1;
        case (op)
            OP_ADD, OP_SUB, OP_NEGA, OP_INC, OP_DEC: begin
                result = sum[31:0];
                cy     = sum[32];
                ov     = add_ovf;
            end
            OP_NOTA: result = ~a;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_LT:   result = {31'd0, lt_ab};
            OP_LE:   result = {31'd0, lt_ab | eq_ab};
            OP_GT:   result = {31'd0, ~(lt_ab | eq_ab)};
            OP_GE:   result = {31'd0, ~lt_ab};
            OP_EQ:   result = {31'd0, eq_ab};
            OP_NE:   result = {31'd0, ~eq_ab};
            OP_EQ0:  result = {31'd0, a_zero};
            OP_NE0:  result = {31'd0, ~a_zero};
            OP_GT0:  result = {31'd0, ~(a_neg | a_zero)};
            OP_GE0:  result = {31'd0, ~a_neg};
            OP_LE0:  result = {31'd0, a_neg | a_zero};
            OP_LT0:  result = {31'd0, a_neg};
            // Signed a < 1 is the same as a <= 0
            OP_EQ1:  result = {31'd0, a_one};
            OP_NE1:  result = {31'd0, ~a_one};
            OP_GT1:  result = {31'd0, ~(a_neg | a_zero | a_one)};
            OP_GE1:  result = {31'd0, ~(a_neg | a_zero)};
            OP_LE1:  result = {31'd0, a_neg | a_zero | a_one};
            OP_LT1:  result = {31'd0, a_neg | a_zero};
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/functional_unit_core.sv
// Registered 32-bit functional unit: ALU, shifter, optional multiply-add and select.
// Define FU_MADD_EN to build the multiplier; otherwise 111xxx opcodes are undefined.
module functional_unit_core
    import fu_pkg::*;
(
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] C,
    input  logic [5:0]  INST,
    output logic [31:0] Z,
    output logic [3:0]  FLAGS
);

    logic [31:0] alu_result;
    logic        alu_cy;
    logic        alu_ov;
    logic        alu_valid;
    logic [31:0] next_z;
    logic [3:0]  next_flags;
    logic [31:0] unit_z;
    logic        unit_cy;
    logic        unit_ov;
    logic        unit_valid;

    fu_alu u_alu (
        .a      (A),
        .b      (B),
        .op     (INST),
        .result (alu_result),
        .cy     (alu_cy),
        .ov     (alu_ov),
        .valid  (alu_valid)
    );

`ifdef FU_MADD_EN
    logic [31:0] product;
    logic [31:0] madd_z;

    assign product = A * B;
    assign madd_z  = (INST[5:2] == OP_MADD_PFX) ? product + C : product;
`endif

    always_comb begin
        unit_z     = 32'd0;
        unit_cy    = 1'b0;
        unit_ov    = 1'b0;
        unit_valid = 1'b1;
        case (decode_unit(INST))
            UNIT_ALU: begin
                unit_z     = alu_result;
                unit_cy    = alu_cy;
                unit_ov    = alu_ov;
                unit_valid = alu_valid;
            end
            UNIT_SHIFT: begin
                case (INST)
                    OP_SHR:    unit_z = A >> B[4:0];
                    OP_SHL:    unit_z = A << B[4:0];
                    OP_ASHR:   unit_z = $signed(A) >>> B[4:0];
                    OP_ASHR1:  unit_z = $signed(A) >>> 1;
                    OP_ASHR2:  unit_z = $signed(A) >>> 2;
                    OP_ASHR4:  unit_z = $signed(A) >>> 4;
                    OP_ASHR16: unit_z = $signed(A) >>> 16;
                    default:   unit_valid = 1'b0;
                endcase
            end
            UNIT_MADD: begin
`ifdef FU_MADD_EN
                unit_z = madd_z;
`else
                unit_valid = 1'b0;
`endif
            end
            UNIT_MUX: begin
                case (INST)
                    OP_SEL:      unit_z = (C != 32'd0) ? A : B;
                    OP_SEL_A0:   unit_z = C[0] ? A : 32'd0;
                    OP_SEL_A1:   unit_z = C[0] ? A : 32'd1;
                    OP_SEL_01:   unit_z = C[0] ? 32'd0 : 32'd1;
                    OP_SEL_1OR0: unit_z = C[0] ? 32'd1 : 32'd0;
                    default:     unit_valid = 1'b0;
                endcase
            end
            default: unit_valid = 1'b0;
        endcase
    end

    // Undefined opcodes force both result and every flag (including ZR) to zero
    always_comb begin
        next_z     = 32'd0;
        next_flags = 4'd0;
        if (unit_valid) begin
            next_z              = unit_z;
            next_flags[FLAG_N]  = unit_z[31];
            next_flags[FLAG_ZR] = (unit_z == 32'd0);
            next_flags[FLAG_CY] = unit_cy;
            next_flags[FLAG_OV] = unit_ov;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            Z     <= 32'd0;
            FLAGS <= 4'd0;
        end else begin
            Z     <= next_z;
            FLAGS <= next_flags;
        end
    end

endmodule

// File: tb/tb_functional_unit_core.sv
// Directed bench for functional_unit_core with hand-computed expectations;
// MADD expectations follow whether FU_MADD_EN is defined for the build.
module tb_functional_unit_core;
    import fu_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] c_in;
    logic [5:0]  inst;
    logic [31:0] z_out;
    logic [3:0]  flags_out;

    int compare_count;
    int fail_count;

    functional_unit_core dut (
        .CLOCK (clock),
        .RESET (reset),
        .A     (a_in),
        .B     (b_in),
        .C     (c_in),
        .INST  (inst),
        .Z     (z_out),
        .FLAGS (flags_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive at the falling edge, then sample 1ns after the capturing rising edge
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] c);
        @(negedge clock);
        inst = op;
        a_in = a;
        b_in = b;
        c_in = c;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] exp_z,
                               input logic [3:0] exp_flags);
        compare_count++;
        assert (z_out === exp_z) else begin
            fail_count++;
            $error("[TB] FAIL %s.Z: observed %h expected %h", tag, z_out, exp_z);
        end
        compare_count++;
        assert (flags_out === exp_flags) else begin
            fail_count++;
            $error("[TB] FAIL %s.FLAGS: observed %b expected %b", tag, flags_out, exp_flags);
        end
    endtask

    initial begin
        compare_count = 0;
        fail_count    = 0;
        reset = 1'b1;
        inst  = OP_ADD;
        a_in  = 32'h1234_5678;
        b_in  = 32'h1111_1111;
        c_in  = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_hold", 32'd0, 4'b0000);
        @(negedge clock);
        reset = 1'b0;

        applyStimulus(OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0);
        checkOutput("add_carry", 32'h0000_0000, 4'b0110);
        applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0);
        checkOutput("add_ovf", 32'h8000_0000, 4'b1001);
        applyStimulus(OP_LT, 32'hFFFF_FFFF, 32'd1, 32'd0);
        checkOutput("lt_signed", 32'd1, 4'b0000);
        applyStimulus(OP_SUB, 32'd5, 32'd7, 32'd0);
        checkOutput("sub_neg", 32'hFFFF_FFFE, 4'b1000);
        applyStimulus(OP_SUB, 32'd7, 32'd5, 32'd0);
        checkOutput("sub_pos", 32'd2, 4'b0010);
        applyStimulus(OP_NEGA, 32'd0, 32'd0, 32'd0);
        checkOutput("nega_zero", 32'd0, 4'b0110);
        applyStimulus(OP_DEC, 32'd0, 32'd0, 32'd0);
        checkOutput("dec_zero", 32'hFFFF_FFFF, 4'b1000);
        applyStimulus(OP_INC, 32'h7FFF_FFFF, 32'd0, 32'd0);
        checkOutput("inc_ovf", 32'h8000_0000, 4'b1001);
        applyStimulus(OP_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
        checkOutput("xor", 32'h0FF0_0FF0, 4'b0000);
        applyStimulus(OP_NOTA, 32'hFFFF_FFFF, 32'd0, 32'd0);
        checkOutput("nota", 32'd0, 4'b0100);
        applyStimulus(OP_GE0, 32'd0, 32'd0, 32'd0);
        checkOutput("ge0", 32'd1, 4'b0000);
        applyStimulus(OP_LT0, 32'd0, 32'd0, 32'd0);
        checkOutput("lt0", 32'd0, 4'b0100);
        applyStimulus(OP_GT1, 32'd2, 32'd0, 32'd0);
        checkOutput("gt1", 32'd1, 4'b0000);
        applyStimulus(OP_LT1, 32'd1, 32'd0, 32'd0);
        checkOutput("lt1", 32'd0, 4'b0100);
        applyStimulus(OP_LE, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd0);
        checkOutput("le_equal", 32'd1, 4'b0000);
        applyStimulus(OP_NE, 32'h0000_00AB, 32'h0000_00AB, 32'd0);
        checkOutput("ne_equal", 32'd0, 4'b0100);

        applyStimulus(OP_ASHR4, 32'h8000_0010, 32'd0, 32'd0);
        checkOutput("ashr4", 32'hF800_0001, 4'b1000);
        applyStimulus(OP_SHL, 32'd1, 32'h0000_001F, 32'd0);
        checkOutput("shl31", 32'h8000_0000, 4'b1000);
        applyStimulus(OP_SHR, 32'h8000_0000, 32'h0000_0024, 32'd0);
        checkOutput("shr_b4", 32'h0800_0000, 4'b0000);
        applyStimulus(OP_ASHR, 32'h8000_0000, 32'd31, 32'd0);
        checkOutput("ashr31", 32'hFFFF_FFFF, 4'b1000);
        applyStimulus(OP_ASHR16, 32'h1234_5678, 32'd0, 32'd0);
        checkOutput("ashr16", 32'h0000_1234, 4'b0000);

`ifdef FU_MADD_EN
        applyStimulus(6'b111100, 32'd3, 32'd5, 32'd7);
        checkOutput("madd", 32'h0000_0016, 4'b0000);
        applyStimulus(6'b111011, 32'h0001_0000, 32'h0001_0000, 32'd9);
        checkOutput("mul_wrap", 32'd0, 4'b0100);
`else
        applyStimulus(6'b111100, 32'd3, 32'd5, 32'd7);
        checkOutput("madd_off", 32'd0, 4'b0000);
        applyStimulus(6'b111011, 32'h0001_0000, 32'h0001_0000, 32'd9);
        checkOutput("mul_off", 32'd0, 4'b0000);
`endif

        applyStimulus(OP_SEL, 32'hAAAA_0000, 32'h0000_5555, 32'd0);
        checkOutput("sel_c0", 32'h0000_5555, 4'b0000);
        applyStimulus(OP_SEL, 32'hAAAA_0000, 32'h0000_5555, 32'd2);
        checkOutput("sel_c2", 32'hAAAA_0000, 4'b1000);
        applyStimulus(OP_SEL_01, 32'h1234_0000, 32'd0, 32'd1);
        checkOutput("sel_01", 32'd0, 4'b0100);
        applyStimulus(OP_SEL_A1, 32'h1234_0000, 32'd0, 32'd2);
        checkOutput("sel_a1", 32'd1, 4'b0000);

        applyStimulus(6'b000100, 32'h1234_5678, 32'h1, 32'd0);
        checkOutput("undef_000100", 32'd0, 4'b0000);
        applyStimulus(6'b101111, 32'h8000_0000, 32'h1, 32'd0);
        checkOutput("undef_101111", 32'd0, 4'b0000);
        applyStimulus(6'b110101, 32'h8000_0000, 32'h1, 32'd1);
        checkOutput("undef_110101", 32'd0, 4'b0000);

        // Asynchronous reset between edges, then a discarded in-flight operation
        applyStimulus(OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0);
        checkOutput("pre_reset", 32'h8000_0000, 4'b1001);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 32'd0, 4'b0000);
        applyStimulus(OP_DEC, 32'd0, 32'd0, 32'd0);
        checkOutput("reset_discard", 32'd0, 4'b0000);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(OP_SUB, 32'd7, 32'd5, 32'd0);
        checkOutput("post_reset", 32'd2, 4'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
